pcs_loopback_ctrl: RTL and testbench

Sequences the 10GBASE-R RX→TX loopback path between `pcs_rx` and `pcs_tx`, replacing the bare flop stage. Brings the loopback up only after the transceiver and block lock are stable, forwards only whole frames, and fills the line with idle blocks otherwise. A small FIFO absorbs the independent gearbox stalls of `pcs_rx` (`valid`) and `pcs_tx` (`ready`). Frames cut short by overflow or underflow are terminated with an error block.

---
 rtl/pcs_loopback_ctrl.sv | 154 +++++++++++++++
 tb/tb_pcs_loopback_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_loopback_ctrl.sv
// 10GBASE-R RX->TX loopback sequencer: waits for a stable link, forwards only
// whole frames through a small FIFO, and fills the line with idle/error blocks.
module pcs_loopback_ctrl #(
  parameter int DATA_W      = 64,
  parameter int KEEP_W      = 8,
  parameter int LANE0_CNT_N = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int LOCK_CNT    = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   link_ready_i,
  input  logic                   rx_signal_v_i,
  input  logic                   rx_valid_i,
  input  logic                   rx_ctrl_v_i,
  input  logic                   rx_idle_v_i,
  input  logic                   rx_term_v_i,
  input  logic                   rx_err_v_i,
  input  logic [LANE0_CNT_N-1:0] rx_start_v_i,
  input  logic [DATA_W-1:0]      rx_data_i,
  input  logic [KEEP_W-1:0]      rx_keep_i,
  input  logic                   tx_ready_i,
  output logic                   tx_ctrl_v_o,
  output logic                   tx_idle_v_o,
  output logic                   tx_term_v_o,
  output logic                   tx_err_v_o,
  output logic [LANE0_CNT_N-1:0] tx_start_v_o,
  output logic [DATA_W-1:0]      tx_data_o,
  output logic [KEEP_W-1:0]      tx_keep_o,
  output logic                   tx_nreset_o,
  output logic [1:0]             state_o,
  output logic [15:0]            frame_cnt_o,
  output logic [15:0]            drop_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {S_DOWN, S_LOCKING, S_IDLE, S_FWD} state_t;

  typedef struct packed {
    logic                   ctrl;
    logic                   idle;
    logic [LANE0_CNT_N-1:0] start;
    logic                   term;
    logic                   err;
    logic [KEEP_W-1:0]      keep;
    logic [DATA_W-1:0]      data;
  } entry_t;

  localparam int EW = $bits(entry_t);
  localparam entry_t IDLE_BLK = entry_t'({2'b11, {(EW-2){1'b0}}});
  localparam entry_t ERR_BLK  = entry_t'({1'b1, 1'b0, {LANE0_CNT_N{1'b0}}, 1'b0, 1'b1,
                                          {(KEEP_W+DATA_W){1'b0}}});

  state_t        state;
  logic [CW-1:0] lock_cnt;
  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic          full, empty, link_ok, active, wr_en, rd_en, rd_in_frame, nreset_q;
  entry_t        mem [FIFO_DEPTH];
  entry_t        wr_entry, rd_entry, out_q;
  logic [15:0]   frame_cnt, drop_cnt;

  assign link_ok  = link_ready_i & rx_signal_v_i;
  assign active   = link_ok && (state == S_IDLE || state == S_FWD);
  assign level    = wr_ptr - rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign wr_entry = {rx_ctrl_v_i, rx_idle_v_i, rx_start_v_i, rx_term_v_i, rx_err_v_i,
                     rx_keep_i, rx_data_i};
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Full is sampled before any same-cycle pop, so a full FIFO always drops.
  assign wr_en = active && rx_valid_i && !full && (state == S_FWD || (|rx_start_v_i));
  // A frame is only started once its second word is buffered behind the start.
  assign rd_en = active && tx_ready_i &&
                 (rd_in_frame ? !empty : (level >= (AW+1)'(2)));

  // NOTE: the FIFO storage has no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_DOWN;
      lock_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_in_frame <= 1'b0;
      out_q       <= IDLE_BLK;
      frame_cnt   <= '0;
      drop_cnt    <= '0;
      nreset_q    <= 1'b0;
    end else begin
      if (!link_ok) begin
        state    <= S_DOWN;
        lock_cnt <= '0;
      end else begin
        case (state)
          S_DOWN:    state <= S_LOCKING;
          S_LOCKING: begin
            if (lock_cnt == LOCK_LAST) state <= S_IDLE;
            else lock_cnt <= lock_cnt + 1'b1;
          end
          S_IDLE:    if (wr_en && !rx_term_v_i) state <= S_FWD;
          S_FWD:     if (rx_valid_i && (full || rx_term_v_i)) state <= S_IDLE;
        endcase
      end

      nreset_q <= link_ok && (state == S_IDLE || state == S_FWD ||
                              (state == S_LOCKING && lock_cnt == LOCK_LAST));

      // Link loss flushes everything, so a cut frame never reaches the error path.
      if (!link_ok || state == S_DOWN) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end

      if (!active) begin
        out_q       <= IDLE_BLK;
        rd_in_frame <= 1'b0;
      end else if (tx_ready_i) begin
        if (rd_en) begin
          out_q       <= rd_entry;
          rd_in_frame <= !rd_entry.term;
          if (rd_entry.term && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
        end else if (rd_in_frame) begin
          out_q       <= ERR_BLK;
          rd_in_frame <= 1'b0;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end else begin
          out_q <= IDLE_BLK;
        end
      end
    end
  end

  assign tx_ctrl_v_o  = out_q.ctrl;
  assign tx_idle_v_o  = out_q.idle;
  assign tx_start_v_o = out_q.start;
  assign tx_term_v_o  = out_q.term;
  assign tx_err_v_o   = out_q.err;
  assign tx_keep_o    = out_q.keep;
  assign tx_data_o    = out_q.data;
  assign tx_nreset_o  = nreset_q;
  assign state_o      = state;
  assign frame_cnt_o  = frame_cnt;
  assign drop_cnt_o   = drop_cnt;

endmodule

// File: tb/tb_pcs_loopback_ctrl.sv
// Bench for pcs_loopback_ctrl: randomized frames/stalls against a queue-based
// reference model, plus directed bring-up, overflow, link-loss and reset cases.
module tb_pcs_loopback_ctrl;
  localparam int DEPTH = 8;
  localparam int LOCK  = 16;

  typedef struct packed {
    logic       ctrl;
    logic       idle;
    logic [1:0] start;
    logic       term;
    logic       err;
    logic [7:0] keep;
    logic [63:0] data;
  } blk_t;

  localparam blk_t IDLE_W = blk_t'({2'b11, 76'b0});
  localparam blk_t ERR_W  = blk_t'({1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 72'b0});

  logic clk = 1'b0;
  logic reset;
  logic link_ready, rx_signal, rx_valid, rx_ctrl, rx_idle, rx_term, rx_err, tx_ready;
  logic [1:0]  rx_start;
  logic [63:0] rx_data;
  logic [7:0]  rx_keep;
  logic tx_ctrl, tx_idle, tx_term, tx_err, tx_nreset;
  logic [1:0]  tx_start, state;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic [15:0] frame_cnt, drop_cnt;

  pcs_loopback_ctrl #(
    .DATA_W(64), .KEEP_W(8), .LANE0_CNT_N(2), .FIFO_DEPTH(DEPTH), .LOCK_CNT(LOCK)
  ) dut (
    .clk(clk), .reset(reset),
    .link_ready_i(link_ready), .rx_signal_v_i(rx_signal), .rx_valid_i(rx_valid),
    .rx_ctrl_v_i(rx_ctrl), .rx_idle_v_i(rx_idle), .rx_term_v_i(rx_term),
    .rx_err_v_i(rx_err), .rx_start_v_i(rx_start), .rx_data_i(rx_data),
    .rx_keep_i(rx_keep), .tx_ready_i(tx_ready),
    .tx_ctrl_v_o(tx_ctrl), .tx_idle_v_o(tx_idle), .tx_term_v_o(tx_term),
    .tx_err_v_o(tx_err), .tx_start_v_o(tx_start), .tx_data_o(tx_data),
    .tx_keep_o(tx_keep), .tx_nreset_o(tx_nreset), .state_o(state),
    .frame_cnt_o(frame_cnt), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0..3 = down, locking, idle, forwarding; the FIFO is a queue.
  blk_t m_q[$];
  int   m_phase, m_lock, m_frames, m_drops;
  bit   m_in_frame, m_nreset;
  blk_t m_out;

  task automatic model_reset();
    m_phase = 0; m_lock = 0; m_frames = 0; m_drops = 0;
    m_in_frame = 1'b0; m_nreset = 1'b0; m_out = IDLE_W;
    m_q.delete();
  endtask

  task automatic model_step();
    bit   ok;
    bit   can_fwd;
    bit   do_wr;
    int   lvl;
    int   nphase;
    blk_t w;
    ok      = link_ready && rx_signal;
    w       = {rx_ctrl, rx_idle, rx_start, rx_term, rx_err, rx_keep, rx_data};
    lvl     = m_q.size();
    can_fwd = ok && (m_phase >= 2);
    nphase  = m_phase;
    do_wr   = 1'b0;
    if (!can_fwd) begin
      m_out = IDLE_W;
      m_in_frame = 1'b0;
    end else if (tx_ready) begin
      if ((!m_in_frame && lvl >= 2) || (m_in_frame && lvl > 0)) begin
        m_out = m_q.pop_front();
        m_in_frame = !m_out.term;
        if (m_out.term && m_frames < 65535) m_frames++;
      end else if (m_in_frame) begin
        m_out = ERR_W;
        m_in_frame = 1'b0;
        if (m_drops < 65535) m_drops++;
      end else begin
        m_out = IDLE_W;
      end
    end
    if (!ok) begin
      nphase = 0;
      m_lock = 0;
    end else begin
      case (m_phase)
        0: nphase = 1;
        1: if (m_lock == LOCK - 1) nphase = 2; else m_lock++;
        2: if (rx_valid && rx_start != 2'b00 && lvl < DEPTH) begin
             do_wr = 1'b1;
             if (!rx_term) nphase = 3;
           end
        default: if (rx_valid) begin
             if (lvl == DEPTH) nphase = 2;
             else begin
               do_wr = 1'b1;
               if (rx_term) nphase = 2;
             end
           end
      endcase
    end
    if (do_wr) m_q.push_back(w);
    if (!ok || m_phase == 0) m_q.delete();
    m_phase  = nphase;
    m_nreset = (nphase >= 2);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    @(negedge clk);
    check("tx", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(m_out));
    check("state", 96'({state, tx_nreset}), 96'({2'(m_phase), m_nreset}));
    check("cnt", 96'({frame_cnt, drop_cnt}), 96'({16'(m_frames), 16'(m_drops)}));
  endtask

  blk_t src[$];

  task automatic push_words(input int n, input bit with_start);
    blk_t w;
    for (int i = 0; i < n; i++) begin
      w = '0;
      w.data = {$urandom(), $urandom()};
      w.keep = 8'hFF;
      if (i == 0 && with_start) begin
        w.ctrl = 1'b1;
        w.start = 2'($urandom_range(1, 2));
      end else if (i == n - 1) begin
        w.ctrl = 1'b1;
        w.term = 1'b1;
        w.keep = 8'($urandom());
      end else begin
        w.err = ($urandom_range(15) == 0);
      end
      src.push_back(w);
    end
  endtask

  task automatic drive(input bit v, input bit r);
    blk_t w;
    logic [95:0] junk;
    junk = {$urandom(), $urandom(), $urandom()};
    if (!v) w = junk[77:0];
    else if (src.size() > 0) w = src.pop_front();
    else w = IDLE_W;
    {rx_ctrl, rx_idle, rx_start, rx_term, rx_err, rx_keep, rx_data} = w;
    rx_valid = v;
    tx_ready = r;
    tick();
  endtask

  blk_t ov[8];

  initial begin
    reset = 1'b1; link_ready = 1'b0; rx_signal = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    {rx_ctrl, rx_idle, rx_start, rx_term, rx_err, rx_keep, rx_data} = '0;
    model_reset();

    // Reset state
    repeat (3) drive(1'b0, 1'b1);
    check("rst_state", 96'(state), 96'(0));
    check("rst_nreset", 96'(tx_nreset), 96'(0));
    check("rst_tx", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(IDLE_W));
    reset = 1'b0;

    // Bring-up: LOCK cycles after link first seen high
    repeat (10) drive(1'b0, 1'b1);
    link_ready = 1'b1; rx_signal = 1'b1;
    drive(1'b0, 1'b1);
    check("lock_enter", 96'(state), 96'(1));
    for (int i = 1; i < LOCK; i++) drive(1'b0, 1'b1);
    check("lock_hold", 96'(state), 96'(1));
    check("lock_nreset", 96'(tx_nreset), 96'(0));
    drive(1'b0, 1'b1);
    check("up_state", 96'(state), 96'(2));
    check("up_nreset", 96'(tx_nreset), 96'(1));
    check("up_tx", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(IDLE_W));

    // Mid-frame join, then one clean frame
    push_words(4, 1'b0);
    push_words(8, 1'b1);
    repeat (30) drive(1'b1, 1'b1);
    check("join_frames", 96'(frame_cnt), 96'(1));
    check("join_drops", 96'(drop_cnt), 96'(0));

    // Gearbox stalls on both sides over 100 frames
    for (int f = 0; f < 100; f++) push_words(8, 1'b1);
    for (int c = 0; c < 1000; c++) drive((c % 33) != 5, (c % 33) != 0);
    check("gear_frames", 96'(frame_cnt), 96'(101));
    check("gear_drops", 96'(drop_cnt), 96'(0));

    // Overflow: 16-word frame into a stalled 8-deep FIFO
    push_words(16, 1'b1);
    for (int i = 0; i < 8; i++) ov[i] = src[i];
    repeat (20) drive(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1);
      check("ovf_word", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(ov[i]));
    end
    drive(1'b1, 1'b1);
    check("ovf_err", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(ERR_W));
    check("ovf_drops", 96'(drop_cnt), 96'(1));
    push_words(8, 1'b1);
    repeat (20) drive(1'b1, 1'b1);
    check("ovf_next", 96'(frame_cnt), 96'(102));

    // Link loss mid-frame, relock, next frame forwarded
    push_words(12, 1'b1);
    repeat (5) drive(1'b1, 1'b1);
    rx_signal = 1'b0;
    drive(1'b1, 1'b1);
    check("loss_state", 96'(state), 96'(0));
    check("loss_nreset", 96'(tx_nreset), 96'(0));
    check("loss_tx", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(IDLE_W));
    repeat (2) drive(1'b1, 1'b1);
    rx_signal = 1'b1;
    repeat (20) drive(1'b1, 1'b1);
    push_words(8, 1'b1);
    repeat (25) drive(1'b1, 1'b1);
    check("relock_frames", 96'(frame_cnt), 96'(103));
    check("relock_drops", 96'(drop_cnt), 96'(1));

    // Random frame lengths and random stalls
    for (int f = 0; f < 40; f++) push_words($urandom_range(2, 12), 1'b1);
    for (int c = 0; c < 3000 && src.size() > 0; c++)
      drive($urandom_range(9) != 0, $urandom_range(4) != 0);
    repeat (60) drive(1'b1, 1'b1);

    // Asynchronous reset while forwarding
    src.delete();
    push_words(10, 1'b1);
    repeat (3) drive(1'b1, 1'b1);
    check("pre_rst_fwd", 96'(state), 96'(3));
    #1 reset = 1'b1;
    #1;
    check("arst_state", 96'(state), 96'(0));
    check("arst_nreset", 96'(tx_nreset), 96'(0));
    check("arst_tx", 96'({tx_ctrl, tx_idle, tx_start, tx_term, tx_err, tx_keep, tx_data}), 96'(IDLE_W));
    check("arst_cnt", 96'({frame_cnt, drop_cnt}), 96'(0));
    repeat (2) drive(1'b0, 1'b1);
    reset = 1'b0;
    repeat (2) drive(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
